// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary-neuron parameter loader.
package bnn_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } loader_state_e;

   function automatic int calc_chain_bits(input int neurons, input int inputs, input int bias_bits);
      return neurons * (inputs + bias_bits);
   endfunction

endpackage

// File: rtl/bnn_param_serializer.sv
// Byte-wide shift register feeding the neuron chain MSB-first, with the
// valid/ready acceptance logic and final-byte truncation.
module bnn_param_serializer
   import bnn_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              take_more,
   input  logic              truncate,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              accept,
   output logic              shifting,
   output logic              ser_bit
);

   localparam int CNT_W = $clog2(BYTE_W + 1);

   logic [BYTE_W-1:0] sr;
   logic [CNT_W-1:0]  sr_cnt;

   // Ready at one bit left lets the next byte land without a setup gap.
   assign byte_ready = enable && take_more && (sr_cnt <= CNT_W'(1));
   assign accept     = byte_valid && byte_ready;
   assign shifting   = (sr_cnt != '0);
   assign ser_bit    = shifting && sr[BYTE_W-1];

   always_ff @(posedge clk) begin
      if (!rst_n || !enable) begin
         sr     <= '0;
         sr_cnt <= '0;
      end else if (accept) begin
         sr     <= byte_in;
         sr_cnt <= CNT_W'(BYTE_W);
      end else if (truncate) begin
         sr     <= '0;
         sr_cnt <= '0;
      end else if (shifting) begin
         sr     <= {sr[BYTE_W-2:0], 1'b0};
         sr_cnt <= sr_cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/bnn_param_loader.sv
// Load sequencer for a daisy-chained neuron column: streams host bytes onto
// chain_setup/chain_param for exactly CHAIN_BITS cycles, then reports done.
module bnn_param_loader
   import bnn_pkg::*;
#(
   parameter int NEURONS   = 4,
   parameter int INPUTS    = 8,
   parameter int BIAS_BITS = 3
)(
   input  logic                                             clk,
   input  logic                                             rst_n,
   input  logic                                             start,
   input  logic [BYTE_W-1:0]                                byte_in,
   input  logic                                             byte_valid,
   output logic                                             byte_ready,
   output logic                                             chain_setup,
   output logic                                             chain_param,
   output logic                                             busy,
   output logic                                             done,
   output logic [$clog2(NEURONS*(INPUTS+BIAS_BITS)+1)-1:0] bits_loaded
);

   localparam int CHAIN_BITS = calc_chain_bits(NEURONS, INPUTS, BIAS_BITS);
   localparam int BL_W       = $clog2(CHAIN_BITS + 1);
   localparam int NUM_BYTES  = (CHAIN_BITS + BYTE_W - 1) / BYTE_W;
   localparam int BC_W       = $clog2(NUM_BYTES + 1);

   loader_state_e   state;
   logic [BC_W-1:0] bytes_taken;
   logic            accept;
   logic            shifting;
   logic            ser_bit;
   logic            last_bit;
   logic            take_more;

   assign take_more = (bytes_taken < BC_W'(NUM_BYTES));
   assign last_bit  = shifting && (bits_loaded == BL_W'(CHAIN_BITS - 1));

   bnn_param_serializer u_serializer (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (busy),
      .take_more  (take_more),
      .truncate   (last_bit),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .accept     (accept),
      .shifting   (shifting),
      .ser_bit    (ser_bit)
   );

   assign chain_setup = shifting;
   assign chain_param = ser_bit;

   // The neuron samples chain_param on the same edge that bits_loaded counts it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         bits_loaded <= '0;
         bytes_taken <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= LOAD;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  bits_loaded <= '0;
                  bytes_taken <= '0;
               end
            end
            LOAD: begin
               if (accept) begin
                  bytes_taken <= bytes_taken + BC_W'(1);
               end
               if (shifting) begin
                  bits_loaded <= bits_loaded + BL_W'(1);
                  if (last_bit) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bnn_param_loader.sv
// Randomised bench for bnn_param_loader with a queue-based bit-stream model
// and a downstream neuron-chain shift model.
module tb_bnn_param_loader;

   localparam int CB = 44;
   localparam int NB = 6;
   localparam int PH_IDLE = 0;
   localparam int PH_LOAD = 1;
   localparam int PH_DONE = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic       byte_ready;
   logic       chain_setup;
   logic       chain_param;
   logic       busy;
   logic       done;
   logic [5:0] bits_loaded;

   int checks = 0;
   int errors = 0;

   logic [7:0]    stream [NB];
   logic [CB-1:0] chain_vec = '0;
   logic [47:0]   cat;

   int m_phase = PH_IDLE;
   int m_bits = 0;
   int m_bytes = 0;
   int m_pushed = 0;
   bit pend [$];
   bit check_en = 1'b0;

   int setup_total = 0;
   int setup_run = 0;
   int max_run = 0;

   always #5 clk = ~clk;

   bnn_param_loader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .byte_in     (byte_in),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .chain_setup (chain_setup),
      .chain_param (chain_param),
      .busy        (busy),
      .done        (done),
      .bits_loaded (bits_loaded)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference: accepted bytes become a queue of pending bits, capped at CB per load.
   always @(posedge clk) begin
      bit acc;
      acc = (m_phase == PH_LOAD) && (pend.size() <= 1) && (m_bytes < NB) && byte_valid;
      if (!rst_n) begin
         m_phase  = PH_IDLE;
         m_bits   = 0;
         m_bytes  = 0;
         m_pushed = 0;
         pend.delete();
      end else if (m_phase != PH_LOAD) begin
         if (start) begin
            m_phase  = PH_LOAD;
            m_bits   = 0;
            m_bytes  = 0;
            m_pushed = 0;
            pend.delete();
         end
      end else begin
         if (pend.size() > 0) begin
            void'(pend.pop_front());
            m_bits++;
            if (m_bits == CB) begin
               m_phase = PH_DONE;
               pend.delete();
               acc = 1'b0;
            end
         end
         if (acc) begin
            m_bytes++;
            for (int b = 7; b >= 0; b--) begin
               if (m_pushed < CB) begin
                  pend.push_back(byte_in[b]);
                  m_pushed++;
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      if (chain_setup) chain_vec <= {chain_vec[CB-2:0], chain_param};
   end

   always @(negedge clk) begin
      bit exp_setup;
      exp_setup = (pend.size() > 0);
      if (chain_setup === 1'b1) begin
         setup_total++;
         setup_run++;
         if (setup_run > max_run) max_run = setup_run;
      end else begin
         setup_run = 0;
      end
      if (check_en) begin
         checkOutput("busy", 64'(busy), 64'(m_phase == PH_LOAD));
         checkOutput("done", 64'(done), 64'(m_phase == PH_DONE));
         checkOutput("bits_loaded", 64'(bits_loaded), 64'(m_bits));
         checkOutput("chain_setup", 64'(chain_setup), 64'(exp_setup));
         checkOutput("chain_param", 64'(chain_param), 64'(exp_setup ? pend[0] : 1'b0));
         checkOutput("byte_ready", 64'(byte_ready),
                     64'((m_phase == PH_LOAD) && (pend.size() <= 1) && (m_bytes < NB)));
      end
   end

   task automatic clearMonitor();
      setup_total = 0;
      setup_run = 0;
      max_run = 0;
   endtask

   // gap < 0 picks a random stall per byte; start_at/reset_at < 0 disable those events.
   task automatic applyStimulus(input int gap, input int start_at, input int reset_at);
      int idx;
      int wait_cnt;
      int cyc;
      bit acc;
      bit pulsed;
      idx = 0;
      wait_cnt = 0;
      cyc = 0;
      pulsed = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      byte_in = stream[0];
      byte_valid = 1'b1;
      while (!done && cyc < 600) begin
         @(posedge clk);
         acc = byte_valid && byte_ready;
         #2;
         cyc++;
         start = 1'b0;
         if (acc) begin
            idx++;
            byte_valid = 1'b0;
            wait_cnt = (gap < 0) ? int'($urandom_range(0, 12)) : gap;
         end
         if (!byte_valid && idx < NB) begin
            if (wait_cnt > 0) wait_cnt--;
            else begin
               byte_valid = 1'b1;
               byte_in = stream[idx];
            end
         end
         if (start_at >= 0 && !pulsed && int'(bits_loaded) == start_at) begin
            start = 1'b1;
            pulsed = 1'b1;
         end
         if (reset_at >= 0 && int'(bits_loaded) == reset_at) begin
            rst_n = 1'b0;
            byte_valid = 1'b0;
            start = 1'b0;
            @(posedge clk);
            #2;
            rst_n = 1'b1;
            return;
         end
      end
      byte_valid = 1'b0;
      start = 1'b0;
      checkOutput("load_done", 64'(done), 64'd1);
   endtask

   task automatic setDefaultStream();
      stream[0] = 8'hA5; stream[1] = 8'h3C; stream[2] = 8'hFF;
      stream[3] = 8'h00; stream[4] = 8'h81; stream[5] = 8'hF0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b1;
      byte_valid = 1'b1;
      byte_in = 8'hFF;
      repeat (3) begin
         @(negedge clk);
         checkOutput("rst_outputs", 64'({busy, done, chain_setup, chain_param, byte_ready}), 64'd0);
         checkOutput("rst_bits", 64'(bits_loaded), 64'd0);
      end
      check_en = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      start = 1'b0;
      byte_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("idle_after_rst", 64'({busy, done}), 64'd0);

      setDefaultStream();
      clearMonitor();
      applyStimulus(0, -1, -1);
      repeat (2) @(posedge clk);
      #2;
      checkOutput("full_setup_total", 64'(setup_total), 64'd44);
      checkOutput("full_setup_run", 64'(max_run), 64'd44);
      checkOutput("full_chain", 64'(chain_vec), 64'h0A53CFF0081F);

      clearMonitor();
      applyStimulus(13, -1, -1);
      repeat (2) @(posedge clk);
      #2;
      checkOutput("stall_setup_total", 64'(setup_total), 64'd44);
      checkOutput("stall_setup_run", 64'(max_run), 64'd8);
      checkOutput("stall_chain", 64'(chain_vec), 64'h0A53CFF0081F);

      clearMonitor();
      applyStimulus(0, 20, -1);
      repeat (2) @(posedge clk);
      #2;
      checkOutput("ignstart_bits", 64'(bits_loaded), 64'd44);
      checkOutput("ignstart_setup_total", 64'(setup_total), 64'd44);
      checkOutput("ignstart_chain", 64'(chain_vec), 64'h0A53CFF0081F);

      for (int i = 0; i < NB; i++) stream[i] = 8'h00;
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      checkOutput("reload_state", 64'({done, busy}), 64'b01);
      checkOutput("reload_bits", 64'(bits_loaded), 64'd0);
      applyStimulus(0, -1, -1);
      repeat (2) @(posedge clk);
      #2;
      checkOutput("reload_chain", 64'(chain_vec), 64'd0);

      setDefaultStream();
      applyStimulus(0, -1, 17);
      checkOutput("midrst_setup", 64'(chain_setup), 64'd0);
      checkOutput("midrst_bits", 64'(bits_loaded), 64'd0);
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      applyStimulus(0, -1, -1);
      repeat (2) @(posedge clk);
      #2;
      checkOutput("after_midrst_chain", 64'(chain_vec), 64'h0A53CFF0081F);

      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < NB; i++) stream[i] = 8'($urandom);
         cat = {stream[0], stream[1], stream[2], stream[3], stream[4], stream[5]};
         clearMonitor();
         repeat ($urandom_range(0, 4)) @(posedge clk);
         #2;
         applyStimulus(-1, -1, -1);
         repeat (2) @(posedge clk);
         #2;
         checkOutput("rand_setup_total", 64'(setup_total), 64'd44);
         checkOutput("rand_chain", 64'(chain_vec), 64'(cat[47:4]));
      end

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
